// File: rtl/mem_dbus_ctrl.sv
// Memory-stage to data-bus handshake controller: holds one request on the bus until data_ok, stalls meanwhile.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
package mem_dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module mem_dbus_ctrl
  import mem_dbus_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  dbus_req_t   i_req_in,
  input  logic        i_flush,
  input  logic        i_advance,
  input  dbus_resp_t  i_dresp,
  output dbus_req_t   o_dreq,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic [63:0] o_resp_data,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  dbus_req_t   r_dreq;
  logic        r_squash;
  logic        r_resp_valid;
  logic [63:0] r_resp_data;
  logic        w_accept;
  logic        w_timeout;
  logic        w_finish;
  logic        w_unused;

  // addr_ok only tells us the address phase was taken; completion is data_ok alone
  assign w_unused = i_dresp.addr_ok;

  assign w_accept = i_req_in.valid & ~i_flush &
                    ((r_state == S_IDLE) | ((r_state == S_DONE) & i_advance));
  assign w_finish = i_dresp.data_ok | w_timeout;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  assign w_timeout = (r_state == S_BUSY) & ~i_dresp.data_ok &
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == S_BUSY)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_bus_err <= 1'b1;
    end
  end

  assign o_bus_err = r_bus_err;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = CNT_W'(TIMEOUT_CYC);
  assign w_timeout    = 1'b0;
  assign o_bus_err    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_dreq       <= '0;
      r_squash     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dreq       <= i_req_in;
            r_dreq.valid <= 1'b1;
            r_squash     <= 1'b0;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_flush)
            r_squash <= 1'b1;
          // a started bus transaction is never retracted; a squash only discards its result
          if (w_finish) begin
            r_dreq.valid <= 1'b0;
            r_resp_data  <= i_dresp.data_ok ? i_dresp.data : 64'hDEAD_BEEF_DEAD_BEEF;
            if (r_squash | i_flush) begin
              r_state <= S_IDLE;
            end else begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (i_flush) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else if (i_advance) begin
            r_resp_valid <= 1'b0;
            if (w_accept) begin
              r_dreq       <= i_req_in;
              r_dreq.valid <= 1'b1;
              r_squash     <= 1'b0;
              r_state      <= S_BUSY;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // the accept cycle stalls combinationally so the requesting instruction holds in place
  assign o_stall      = (r_state == S_BUSY) | w_accept;
  assign o_dreq       = r_dreq;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed testbench for mem_dbus_ctrl; the timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_dbus_ctrl;
  import mem_dbus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        advance;
  dbus_req_t   req_in;
  dbus_resp_t  dresp;
  dbus_req_t   dreq;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_dbus_ctrl #(.TIMEOUT_CYC(8), .CNT_W(9)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_in     (req_in),
    .i_flush      (flush),
    .i_advance    (advance),
    .i_dresp      (dresp),
    .o_dreq       (dreq),
    .o_stall      (stall),
    .o_resp_valid (resp_valid),
    .o_resp_data  (resp_data),
    .o_bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_in  = '0;
    dresp   = '0;
    flush   = 1'b0;
    advance = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #13;
    n_tests++; if (dreq !== '0) begin n_fail++; $display("FAIL reset_dreq got %h exp 0", dreq); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_tests++; if (resp_data !== 64'h0) begin n_fail++; $display("FAIL reset_resp_data got %h exp 0", resp_data); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    dbus_req_t r;
    int nstall;
    r = '{valid: 1'b1, addr: 32'h8000_0000, size: 3'd3, strobe: 8'hFF, data: 64'h0};
    idle_inputs();
    req_in = r;
    #1;
    nstall = stall ? 1 : 0;
    tick();
    req_in = '0;
    for (int k = 1; k <= 3; k++) begin
      dresp.data_ok = (k == 3);
      dresp.data    = (k == 3) ? 64'h1122_3344_5566_7788 : 64'h0;
      #1;
      if (stall) nstall++;
      n_tests++; if (dreq !== r) begin n_fail++; $display("FAIL load_dreq_busy%0d got %h exp %h", k, dreq, r); end
      n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL load_rv_busy%0d got %b exp 0", k, resp_valid); end
      tick();
    end
    dresp = '0;
    #1;
    if (stall) nstall++;
    n_tests++; if (nstall != 4) begin n_fail++; $display("FAIL load_stall_cycles got %0d exp 4", nstall); end
    n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL load_rv_done got %b exp 1", resp_valid); end
    n_tests++; if (resp_data !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL load_data got %h exp 1122334455667788", resp_data); end
    n_tests++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL load_dreq_drop got %b exp 0", dreq.valid); end
    tick();
    n_tests++; if (resp_valid !== 1'b1 || resp_data !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL load_hold got %b/%h exp 1/1122334455667788", resp_valid, resp_data); end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    #1;
    n_tests++; if (resp_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL load_to_idle got rv=%b stall=%b exp 0/0", resp_valid, stall); end
  endtask

  task automatic test_store();
    dbus_req_t r;
    int nvalid;
    r = '{valid: 1'b1, addr: 32'h8000_0003, size: 3'd0, strobe: 8'h08, data: 64'h0000_0000_AB00_0000};
    idle_inputs();
    req_in = r;
    nvalid = 0;
    tick();
    req_in = '0;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h5555_6666_7777_8888;
    #1;
    if (dreq.valid) nvalid++;
    n_tests++; if (dreq !== r) begin n_fail++; $display("FAIL store_fields got %h exp %h", dreq, r); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL store_stall_busy got %b exp 1", stall); end
    tick();
    dresp = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (dreq.valid) nvalid++;
      if (k == 0) begin
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_stall_drop got %b exp 0", stall); end
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL store_rv got %b exp 1", resp_valid); end
        advance = 1'b1;
      end
      tick();
      advance = 1'b0;
    end
    n_tests++; if (nvalid != 1) begin n_fail++; $display("FAIL store_valid_cycles got %0d exp 1", nvalid); end
  endtask

  task automatic test_back_to_back();
    dbus_req_t r1, r2;
    r1 = '{valid: 1'b1, addr: 32'h0000_0100, size: 3'd2, strobe: 8'h0F, data: 64'h0};
    r2 = '{valid: 1'b1, addr: 32'h0000_0200, size: 3'd2, strobe: 8'hF0, data: 64'h0};
    idle_inputs();
    req_in = r1;
    tick();
    req_in = '0;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hAAAA_0000_0000_0001;
    tick();
    dresp = '0;
    req_in  = r2;
    advance = 1'b1;
    #1;
    n_tests++; if (dreq.addr !== 32'h0000_0100 || dreq.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_first got addr=%h v=%b exp 00000100/0", dreq.addr, dreq.valid); end
    n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rv_first got %b exp 1", resp_valid); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_stall got %b exp 1", stall); end
    tick();
    req_in  = '0;
    advance = 1'b0;
    #1;
    n_tests++; if (dreq !== r2) begin n_fail++; $display("FAIL b2b_second got %h exp %h", dreq, r2); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rv_busy got %b exp 0", resp_valid); end
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hBBBB_0000_0000_0002;
    tick();
    dresp = '0;
    #1;
    n_tests++; if (resp_data !== 64'hBBBB_0000_0000_0002 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_data got %h/%b exp bbbb000000000002/1", resp_data, resp_valid); end
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  task automatic test_flush_busy();
    dbus_req_t r;
    int nvalid;
    r = '{valid: 1'b1, addr: 32'h8000_0040, size: 3'd3, strobe: 8'hFF, data: 64'h0};
    idle_inputs();
    req_in = r;
    nvalid = 0;
    tick();
    req_in = '0;
    for (int k = 1; k <= 5; k++) begin
      flush         = (k == 2);
      dresp.data_ok = (k == 5);
      dresp.data    = 64'hCAFE_F00D_0000_0005;
      #1;
      if (dreq.valid && stall && !resp_valid) nvalid++;
      tick();
    end
    idle_inputs();
    #1;
    n_tests++; if (nvalid != 5) begin n_fail++; $display("FAIL flush_busy_hold got %0d exp 5", nvalid); end
    n_tests++; if (dreq.valid !== 1'b0 || stall !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy_end got v=%b st=%b rv=%b exp 0/0/0", dreq.valid, stall, resp_valid); end
    tick();
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy_idle got %b exp 0", resp_valid); end
  endtask

  task automatic test_flush_idle_done();
    dbus_req_t r;
    r = '{valid: 1'b1, addr: 32'h8000_0080, size: 3'd3, strobe: 8'hFF, data: 64'h0};
    idle_inputs();
    req_in = r;
    flush  = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got %b exp 0", stall); end
    tick();
    n_tests++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_latch got %b exp 0", dreq.valid); end
    flush = 1'b0;
    tick();
    req_in = '0;
    dresp.data_ok = 1'b1;
    tick();
    dresp = '0;
    flush = 1'b1;
    #1;
    n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done_pre got %b exp 1", resp_valid); end
    tick();
    flush = 1'b0;
    tick();
    n_tests++; if (resp_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_done got rv=%b st=%b exp 0/0", resp_valid, stall); end
  endtask

  task automatic test_reset_mid_busy();
    dbus_req_t r;
    r = '{valid: 1'b1, addr: 32'h8000_00C0, size: 3'd3, strobe: 8'hFF, data: 64'h0};
    idle_inputs();
    req_in = r;
    tick();
    req_in = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (dreq !== '0 || stall !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 64'h0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got dreq=%h st=%b rv=%b rd=%h be=%b exp all 0", dreq, stall, resp_valid, resp_data, bus_err); end
    #1;
    rst_n = 1'b1;
    tick();
    n_tests++; if (dreq !== '0 || stall !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release got dreq=%h st=%b rv=%b exp 0", dreq, stall, resp_valid); end
  endtask

  task automatic test_timeout();
    dbus_req_t r;
    int nvalid;
    r = '{valid: 1'b1, addr: 32'h8000_0100, size: 3'd3, strobe: 8'hFF, data: 64'h0};
    idle_inputs();
    req_in = r;
    nvalid = 0;
    tick();
    req_in = '0;
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (dreq.valid && !bus_err) nvalid++;
      tick();
    end
    n_tests++; if (nvalid != 8) begin n_fail++; $display("FAIL timeout_wait got %0d exp 8", nvalid); end
    n_tests++; if (bus_err !== 1'b1 || dreq.valid !== 1'b0) begin n_fail++; $display("FAIL timeout_err got be=%b v=%b exp 1/0", bus_err, dreq.valid); end
    n_tests++; if (resp_data !== 64'hDEAD_BEEF_DEAD_BEEF || resp_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_data got %h/%b exp deadbeefdeadbeef/1", resp_data, resp_valid); end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b exp 1", bus_err); end
`else
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (dreq.valid && stall && !bus_err) nvalid++;
      tick();
    end
    n_tests++; if (nvalid != 20) begin n_fail++; $display("FAIL no_timeout_wait got %0d exp 20", nvalid); end
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0123_4567_89AB_CDEF;
    tick();
    dresp = '0;
    n_tests++; if (resp_data !== 64'h0123_4567_89AB_CDEF || resp_valid !== 1'b1 || bus_err !== 1'b0) begin n_fail++; $display("FAIL no_timeout_done got %h/%b/%b exp 0123456789abcdef/1/0", resp_data, resp_valid, bus_err); end
    advance = 1'b1;
    tick();
    advance = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_flush_busy();
    test_flush_idle_done();
    test_reset_mid_busy();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
